apb2axi_issue_sched: RTL and testbench

- Scheduler between the transaction directory and the AXI AR/AW request builders.
- Each cycle it scans the per-tag PENDING bitmap and picks the next read tag and the next write tag round-robin.
- It presents each picked tag on a valid/ready channel to the matching builder.
- It enforces per-direction outstanding limits, counted from issue and completion events.

---
 rtl/apb2axi_issue_sched.sv | 159 +++++++++++++++
 tb/tb_apb2axi_issue_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_issue_sched.sv
// ---------------------------------------------------------------------------
// apb2axi_issue_sched
//   Picks pending directory tags round-robin and offers them to the AXI AR
//   (read) and AW (write) request builders, one holding stage per direction.
//   Outstanding reads/writes are tracked from issue and completion events and
//   new loads are throttled at MAX_RD_OUT / MAX_WR_OUT.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   sched_en                      allow new picks (held requests still issue)
//   pending_vec, is_write_vec     per-tag PENDING and direction bits
//   ar_req_valid/tag/ready        read tag channel to the AR builder
//   aw_req_valid/tag/ready        write tag channel to the AW builder
//   rd_issued, wr_issued          handshake pulses back to the directory
//   rd_cpl, wr_cpl                one completion retired per pulse
//   rd_out_cnt, wr_out_cnt        outstanding counts
//   cnt_err                       sticky: completion seen with count at zero
// ---------------------------------------------------------------------------
module apb2axi_issue_sched #(
    parameter  int TAG_W      = 4,
    parameter  int MAX_RD_OUT = 8,
    parameter  int MAX_WR_OUT = 8,
    localparam int N_TAG      = 1 << TAG_W,
    localparam int CNT_W      = $clog2(N_TAG + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             sched_en,
    input  logic [N_TAG-1:0] pending_vec,
    input  logic [N_TAG-1:0] is_write_vec,
    output logic             ar_req_valid,
    output logic [TAG_W-1:0] ar_req_tag,
    input  logic             ar_req_ready,
    output logic             aw_req_valid,
    output logic [TAG_W-1:0] aw_req_tag,
    input  logic             aw_req_ready,
    output logic             rd_issued,
    output logic             wr_issued,
    input  logic             rd_cpl,
    input  logic             wr_cpl,
    output logic [CNT_W-1:0] rd_out_cnt,
    output logic [CNT_W-1:0] wr_out_cnt,
    output logic             cnt_err
);

    // First set bit of mask strictly after ptr, wrapping modulo N_TAG.
    // At i = N_TAG the index wraps back onto ptr itself.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [N_TAG-1:0] mask,
                                                 input logic [TAG_W-1:0] ptr);
        logic [TAG_W-1:0] idx;
        logic [TAG_W-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_TAG; i++) begin
            idx = ptr + TAG_W'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [N_TAG-1:0] tag_bit(input logic [TAG_W-1:0] t);
        logic [N_TAG-1:0] m;
        m    = '0;
        m[t] = 1'b1;
        return m;
    endfunction

    // A simultaneous issue and completion cancel; a lone completion at zero
    // leaves the count at zero (the error flag is raised separately).
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic hs, input logic cpl);
        if (hs && !cpl)
            return cnt + CNT_W'(1);
        else if (!hs && cpl && cnt != '0)
            return cnt - CNT_W'(1);
        return cnt;
    endfunction

    logic             ar_hs, aw_hs;
    logic [N_TAG-1:0] held_mask, last_issued_mask;
    logic [N_TAG-1:0] rd_cand, wr_cand;
    logic [CNT_W:0]   rd_sum, wr_sum;
    logic             rd_room, wr_room;
    logic             ar_load, aw_load;
    logic [TAG_W-1:0] rd_pick, wr_pick;
    logic [TAG_W-1:0] rd_ptr, wr_ptr;
    logic             rd_under, wr_under;

    always_comb begin
        ar_hs = ar_req_valid & ar_req_ready;
        aw_hs = aw_req_valid & aw_req_ready;

        // Tags already offered, or handshaked last cycle (the directory drops
        // PENDING one cycle late), must not be picked again.
        held_mask = (ar_req_valid ? tag_bit(ar_req_tag) : '0)
                  | (aw_req_valid ? tag_bit(aw_req_tag) : '0);
        rd_cand   = pending_vec & ~is_write_vec & ~held_mask & ~last_issued_mask;
        wr_cand   = pending_vec &  is_write_vec & ~held_mask & ~last_issued_mask;

        // The handshake in flight this cycle is counted so a new load can
        // never push the outstanding count past its limit.
        rd_sum  = {1'b0, rd_out_cnt} + {{CNT_W{1'b0}}, ar_hs};
        wr_sum  = {1'b0, wr_out_cnt} + {{CNT_W{1'b0}}, aw_hs};
        rd_room = rd_sum < (CNT_W+1)'(MAX_RD_OUT);
        wr_room = wr_sum < (CNT_W+1)'(MAX_WR_OUT);

        ar_load = sched_en & (~ar_req_valid | ar_hs) & (|rd_cand) & rd_room;
        aw_load = sched_en & (~aw_req_valid | aw_hs) & (|wr_cand) & wr_room;
        rd_pick = rr_pick(rd_cand, rd_ptr);
        wr_pick = rr_pick(wr_cand, wr_ptr);

        rd_under = rd_cpl & ~ar_hs & (rd_out_cnt == '0);
        wr_under = wr_cpl & ~aw_hs & (wr_out_cnt == '0);
    end

    assign rd_issued = ar_hs;
    assign wr_issued = aw_hs;

    // Holding stage, round-robin pointers and outstanding counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_req_valid     <= 1'b0;
            ar_req_tag       <= '0;
            aw_req_valid     <= 1'b0;
            aw_req_tag       <= '0;
            rd_ptr           <= TAG_W'(N_TAG - 1);
            wr_ptr           <= TAG_W'(N_TAG - 1);
            rd_out_cnt       <= '0;
            wr_out_cnt       <= '0;
            cnt_err          <= 1'b0;
            last_issued_mask <= '0;
        end else begin
            if (ar_load) begin
                ar_req_valid <= 1'b1;
                ar_req_tag   <= rd_pick;
            end else if (ar_hs) begin
                ar_req_valid <= 1'b0;
            end
            if (aw_load) begin
                aw_req_valid <= 1'b1;
                aw_req_tag   <= wr_pick;
            end else if (aw_hs) begin
                aw_req_valid <= 1'b0;
            end
            if (ar_hs) rd_ptr <= ar_req_tag;
            if (aw_hs) wr_ptr <= aw_req_tag;
            rd_out_cnt       <= cnt_next(rd_out_cnt, ar_hs, rd_cpl);
            wr_out_cnt       <= cnt_next(wr_out_cnt, aw_hs, wr_cpl);
            cnt_err          <= cnt_err | rd_under | wr_under;
            last_issued_mask <= (ar_hs ? tag_bit(ar_req_tag) : '0)
                              | (aw_hs ? tag_bit(aw_req_tag) : '0);
        end
    end

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_issue_sched
//   Directed scenarios followed by randomized traffic. A small directory model
//   presents PENDING tags; a behavioural reference model predicts every
//   cycle's offered tags, issue pulses, counts and error flag into a queue,
//   and an independent monitor pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_apb2axi_issue_sched;

    localparam int TAG_W = 4;
    localparam int N     = 1 << TAG_W;
    localparam int MAXR  = 2;
    localparam int MAXW  = 4;
    localparam int CNT_W = $clog2(N + 1);

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             sched_en = 1'b0;
    logic [N-1:0]     pending_vec = '0;
    logic [N-1:0]     is_write_vec = '0;
    logic             ar_req_valid, aw_req_valid;
    logic [TAG_W-1:0] ar_req_tag, aw_req_tag;
    logic             ar_req_ready = 1'b0, aw_req_ready = 1'b0;
    logic             rd_issued, wr_issued;
    logic             rd_cpl = 1'b0, wr_cpl = 1'b0;
    logic [CNT_W-1:0] rd_out_cnt, wr_out_cnt;
    logic             cnt_err;

    apb2axi_issue_sched #(.TAG_W(TAG_W), .MAX_RD_OUT(MAXR), .MAX_WR_OUT(MAXW)) dut (
        .aclk(aclk), .aresetn(aresetn), .sched_en(sched_en),
        .pending_vec(pending_vec), .is_write_vec(is_write_vec),
        .ar_req_valid(ar_req_valid), .ar_req_tag(ar_req_tag), .ar_req_ready(ar_req_ready),
        .aw_req_valid(aw_req_valid), .aw_req_tag(aw_req_tag), .aw_req_ready(aw_req_ready),
        .rd_issued(rd_issued), .wr_issued(wr_issued),
        .rd_cpl(rd_cpl), .wr_cpl(wr_cpl),
        .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt), .cnt_err(cnt_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int ar_v; int ar_t; int aw_v; int aw_t;
        int rd_i; int wr_i; int rc; int wc; int err;
    } exp_t;

    exp_t exp_q[$];
    int   rd_log[$];
    int   wr_log[$];
    int   both_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: index 0 = read direction, 1 = write direction
    bit m_v[2];
    int m_t[2];
    int m_ptr[2];
    int m_cnt[2];
    bit m_err;
    bit m_last[N];
    int max_out[2] = '{MAXR, MAXW};

    // Directory model: a handshaked tag stays PENDING one more cycle
    bit d_pend[N];
    bit d_isw[N];
    bit d_clr[N];

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_log(input string name, input int act[$], input int want[$]);
        check({name, "_len"}, act.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            check(name, (i < act.size()) ? act[i] : -1, want[i]);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 0; m_t[d] = 0; m_ptr[d] = N - 1; m_cnt[d] = 0;
        end
        m_err = 0;
        for (int t = 0; t < N; t++) begin
            m_last[t] = 0; d_pend[t] = 0; d_isw[t] = 0; d_clr[t] = 0;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge aclk);
        aresetn = 1'b0;
        sched_en = 1'b0; ar_req_ready = 1'b0; aw_req_ready = 1'b0;
        rd_cpl = 1'b0; wr_cpl = 1'b0;
        #1;
        check("rst_ar_valid", int'(ar_req_valid), 0);
        check("rst_aw_valid", int'(aw_req_valid), 0);
        check("rst_ar_tag", int'(ar_req_tag), 0);
        check("rst_aw_tag", int'(aw_req_tag), 0);
        check("rst_rd_cnt", int'(rd_out_cnt), 0);
        check("rst_wr_cnt", int'(wr_out_cnt), 0);
        check("rst_cnt_err", int'(cnt_err), 0);
        model_reset();
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(e);
        rd_log.delete();
        wr_log.delete();
        both_cnt = 0;
    endtask

    // Drive one cycle of inputs and advance the reference model.
    task automatic cycle(input bit en, input bit ar_rdy, input bit aw_rdy,
                         input bit rcpl, input bit wcpl);
        exp_t e;
        bit   rdy[2];
        bit   cpl[2];
        bit   hs[2];
        bit   nv[2];
        int   nt[2];
        int   best;
        int   t;
        @(negedge aclk);
        aresetn = 1'b1;
        sched_en = en; ar_req_ready = ar_rdy; aw_req_ready = aw_rdy;
        rd_cpl = rcpl; wr_cpl = wcpl;
        for (int k = 0; k < N; k++) begin
            pending_vec[k]  = d_pend[k];
            is_write_vec[k] = d_isw[k];
        end
        #1;
        rdy[0] = ar_rdy; rdy[1] = aw_rdy;
        cpl[0] = rcpl;   cpl[1] = wcpl;
        for (int d = 0; d < 2; d++) hs[d] = m_v[d] && rdy[d];
        e = '{int'(m_v[0]), m_t[0], int'(m_v[1]), m_t[1],
              int'(hs[0]), int'(hs[1]), m_cnt[0], m_cnt[1], int'(m_err)};
        exp_q.push_back(e);

        for (int d = 0; d < 2; d++) begin
            best = -1;
            for (int k = 1; k <= N; k++) begin
                t = (m_ptr[d] + k) % N;
                if (best < 0 && d_pend[t] && (d_isw[t] == (d == 1)) && !m_last[t]
                    && !(m_v[0] && m_t[0] == t) && !(m_v[1] && m_t[1] == t))
                    best = t;
            end
            nv[d] = m_v[d] && !hs[d];
            nt[d] = m_t[d];
            if (en && (!m_v[d] || hs[d]) && best >= 0 && (m_cnt[d] + int'(hs[d])) < max_out[d]) begin
                nv[d] = 1;
                nt[d] = best;
            end
        end

        for (int k = 0; k < N; k++) begin
            if (d_clr[k]) d_pend[k] = 0;
            d_clr[k]  = 0;
            m_last[k] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            if (hs[d]) begin
                m_last[m_t[d]] = 1;
                d_clr[m_t[d]]  = 1;
                m_ptr[d]       = m_t[d];
            end
            if (hs[d] && !cpl[d]) m_cnt[d]++;
            else if (!hs[d] && cpl[d]) begin
                if (m_cnt[d] == 0) m_err = 1;
                else m_cnt[d]--;
            end
            m_v[d] = nv[d];
            m_t[d] = nt[d];
        end
    endtask

    task automatic settle();
        #3;
    endtask

    // Monitor: pops one expectation per cycle and compares what the DUT shows
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ar_req_valid", int'(ar_req_valid), e.ar_v);
                if (e.ar_v != 0) check("ar_req_tag", int'(ar_req_tag), e.ar_t);
                check("aw_req_valid", int'(aw_req_valid), e.aw_v);
                if (e.aw_v != 0) check("aw_req_tag", int'(aw_req_tag), e.aw_t);
                check("rd_issued", int'(rd_issued), e.rd_i);
                check("wr_issued", int'(wr_issued), e.wr_i);
                check("rd_out_cnt", int'(rd_out_cnt), e.rc);
                check("wr_out_cnt", int'(wr_out_cnt), e.wc);
                check("cnt_err", int'(cnt_err), e.err);
                if (rd_issued) rd_log.push_back(int'(ar_req_tag));
                if (wr_issued) wr_log.push_back(int'(aw_req_tag));
                if (rd_issued && wr_issued) both_cnt++;
            end
        end
    end

    initial begin
        int w[$];
        int t;
        model_reset();

        // Single read of tag 4; PENDING lingers one cycle after the issue
        do_reset();
        d_pend[4] = 1;
        repeat (4) cycle(1, 1, 1, 0, 0);
        settle();
        w.delete(); w.push_back(4);
        check_log("single_rd", rd_log, w);
        check("single_rd_cnt", int'(rd_out_cnt), 1);
        cycle(1, 1, 1, 1, 0);

        // Round-robin over tags 2, 9, 15 twice, pointer wrapping from 15
        do_reset();
        foreach (w[i]) w[i] = 0;
        d_pend[2] = 1; d_pend[9] = 1; d_pend[15] = 1;
        d_isw[2]  = 1; d_isw[9]  = 1; d_isw[15]  = 1;
        repeat (7) cycle(1, 1, 1, 0, 0);
        repeat (3) cycle(1, 1, 1, 0, 1);
        d_pend[2] = 1; d_pend[9] = 1; d_pend[15] = 1;
        repeat (7) cycle(1, 1, 1, 0, 0);
        settle();
        w.delete();
        w.push_back(2); w.push_back(9); w.push_back(15);
        w.push_back(2); w.push_back(9); w.push_back(15);
        check_log("rr_wrap", wr_log, w);

        // Concurrent read tag 3 and write tag 5
        do_reset();
        d_pend[3] = 1; d_pend[5] = 1; d_isw[5] = 1;
        repeat (4) cycle(1, 1, 1, 0, 0);
        settle();
        check("mixed_both_same_cycle", both_cnt, 1);
        w.delete(); w.push_back(3);
        check_log("mixed_rd", rd_log, w);
        w.delete(); w.push_back(5);
        check_log("mixed_wr", wr_log, w);

        // Backpressure: tag 7 held while PENDING drops and sched_en is low
        do_reset();
        d_pend[7] = 1;
        cycle(1, 0, 1, 0, 0);
        d_pend[7] = 0;
        repeat (5) cycle(0, 0, 1, 0, 0);
        check("bp_valid_held", int'(ar_req_valid), 1);
        check("bp_tag_held", int'(ar_req_tag), 7);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        settle();
        w.delete(); w.push_back(7);
        check_log("bp_rd", rd_log, w);

        // Read limit of 2 with four reads pending
        do_reset();
        for (int k = 0; k < 4; k++) d_pend[k] = 1;
        repeat (5) cycle(1, 1, 1, 0, 0);
        check("limit_cnt_max", int'(rd_out_cnt), MAXR);
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 1, 0, 0);
        check("limit_cnt_hs_cpl", int'(rd_out_cnt), 1);
        settle();
        w.delete(); w.push_back(0); w.push_back(1); w.push_back(2);
        check_log("limit_rd", rd_log, w);

        // Write completion with nothing outstanding
        do_reset();
        cycle(1, 1, 1, 0, 1);
        cycle(1, 1, 1, 0, 0);
        check("underflow_err", int'(cnt_err), 1);
        check("underflow_cnt", int'(wr_out_cnt), 0);

        // Reset while a read is held
        do_reset();
        d_pend[6] = 1;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("pre_reset_ar_valid", int'(ar_req_valid), 1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 2) == 0) begin
                t = $urandom_range(0, N - 1);
                if (!d_pend[t] && !d_clr[t]) begin
                    d_pend[t] = 1;
                    d_isw[t]  = $urandom_range(0, 1) == 1;
                end
            end
            if ($urandom_range(0, 30) == 0) d_pend[$urandom_range(0, N - 1)] = 0;
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  (m_cnt[0] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0),
                  (m_cnt[1] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0));
        end
        cycle(0, 0, 0, 0, 0);
        settle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
